// File: rtl/step_controller.sv
// step_controller
//   Gates a slow divided clock into one-cycle CPU clock-enable pulses, either
//   free-running or one pulse per debounced push-button press, with a sticky
//   halt state that only reset can leave.
//
// Ports
//   clock       in   system clock, all state on rising edge
//   reset       in   asynchronous active-low reset
//   slowClock   in   divided clock, asynchronous, rising edge = tick
//   runMode     in   raw switch, 1 = free run, 0 = single step
//   stepButton  in   raw bouncing push-button, active high
//   halt        in   CPU halt request, synchronous to clock
//   cpuEnable   out  one-cycle CPU clock-enable pulse (registered)
//   state       out  registered FSM state (IDLE/RUN/STEP_WAIT/HALTED)
//   stepCount   out  number of cpuEnable pulses issued, wraps
//
// Build option
//   STEP_COUNTER_EN  defined: stepCount counts pulses; undefined: stepCount = 0
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   slowClock,
  input  logic                   runMode,
  input  logic                   stepButton,
  input  logic                   halt,
  output logic                   cpuEnable,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] stepCount
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } state_e;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // 2-flop synchronizers; bit [1] is the usable output
  logic [1:0] slow_sync_q, slow_sync_d;
  logic [1:0] run_sync_q,  run_sync_d;
  logic [1:0] btn_sync_q,  btn_sync_d;

  // vld_pipe[1] set once the synchronizer outputs carry real samples
  // rather than their reset values
  logic [1:0] vld_pipe_q, vld_pipe_d;

  // Edge detector. slow_arm_q keeps a slowClock that is already high at
  // reset release from producing a tick: a low level must be observed first.
  logic slow_prev_q, slow_prev_d;
  logic slow_arm_q,  slow_arm_d;
  logic tick;

  // Debouncer
  logic            db_lvl_q, db_lvl_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  // FSM / output pulse
  state_e state_q, state_d;
  logic   cpu_en_q, cpu_en_d;

  logic slow_s, run_s, btn_s;
  assign slow_s = slow_sync_q[1];
  assign run_s  = run_sync_q[1];
  assign btn_s  = btn_sync_q[1];

  always_comb begin
    slow_sync_d = {slow_sync_q[0], slowClock};
    run_sync_d  = {run_sync_q[0],  runMode};
    btn_sync_d  = {btn_sync_q[0],  stepButton};
    vld_pipe_d  = {vld_pipe_q[0],  1'b1};
  end

  always_comb begin
    slow_prev_d = slow_s;
    slow_arm_d  = slow_arm_q | (vld_pipe_q[1] & ~slow_s);
    tick        = slow_arm_q & slow_s & ~slow_prev_q;
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count. The change is accepted on the
  // DEBOUNCE_CYCLES-th disagreeing sample, and a 0->1 acceptance is a press.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (btn_s != db_lvl_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl_d = btn_s;
        press    = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // halt beats everything, including a tick in the same cycle
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt)       state_d = HALTED;
        else if (run_s) state_d = RUN;
        else if (press) state_d = STEP_WAIT;
      end
      RUN: begin
        if (halt)        state_d  = HALTED;
        else if (!run_s) state_d  = IDLE;   // tick in this cycle is dropped
        else if (tick)   cpu_en_d = 1'b1;
      end
      STEP_WAIT: begin
        // presses here are simply not looked at, so they are not queued
        if (halt) state_d = HALTED;
        else if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slow_sync_q <= '0;
      run_sync_q  <= '0;
      btn_sync_q  <= '0;
      vld_pipe_q  <= '0;
      slow_prev_q <= 1'b0;
      slow_arm_q  <= 1'b0;
      db_lvl_q    <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= IDLE;
      cpu_en_q    <= 1'b0;
    end else begin
      slow_sync_q <= slow_sync_d;
      run_sync_q  <= run_sync_d;
      btn_sync_q  <= btn_sync_d;
      vld_pipe_q  <= vld_pipe_d;
      slow_prev_q <= slow_prev_d;
      slow_arm_q  <= slow_arm_d;
      db_lvl_q    <= db_lvl_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
    end
  end

  assign cpuEnable = cpu_en_q;
  assign state     = state_q;

`ifdef STEP_COUNTER_EN
  logic [COUNT_WIDTH-1:0] step_cnt_q, step_cnt_d;

  // counts the pulse during the cycle it is visible; natural wrap
  always_comb step_cnt_d = step_cnt_q + COUNT_WIDTH'(cpu_en_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) step_cnt_q <= '0;
    else        step_cnt_q <= step_cnt_d;
  end

  assign stepCount = step_cnt_q;
`else
  assign stepCount = '0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller
//   Directed bench for step_controller (DEBOUNCE_CYCLES=4, COUNT_WIDTH=16).
//   Stimulus pushes each expected cpuEnable pulse (cycle, stepCount) into a
//   scoreboard; an independent monitor pops on every observed pulse and also
//   flags pulses that are missing or unexpected. State/count spot checks are
//   made inline by the stimulus. Works with or without STEP_COUNTER_EN.
module tb_step_controller;
  localparam int DB = 4;
  localparam int CW = 16;
`ifdef STEP_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          slowClock = 1'b0;
  logic          runMode = 1'b0;
  logic          stepButton = 1'b0;
  logic          halt = 1'b0;
  logic          cpuEnable;
  logic [1:0]    state;
  logic [CW-1:0] stepCount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [CW-1:0] model_cnt = '0;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  step_controller #(.DEBOUNCE_CYCLES(DB), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .slowClock(slowClock), .runMode(runMode),
    .stepButton(stepButton), .halt(halt), .cpuEnable(cpuEnable),
    .state(state), .stepCount(stepCount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] ecnt();
    return CNT_EN ? model_cnt : '0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // one slowClock period: high 10 cycles, low 10 cycles. A pulse is due
  // after the 3rd rising edge following the rise.
  task automatic slow_period(input bit expect_pulse);
    @(negedge clock);
    slowClock = 1'b1;
    if (expect_pulse) begin
      sb.push_back('{cyc + 3, ecnt()});
      model_cnt++;
    end
    idle(10);
    slowClock = 1'b0;
    idle(10);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_cnt = '0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic clean_press();
    @(negedge clock);
    stepButton = 1'b1;
    idle(6);
    stepButton = 1'b0;
    idle(6);
  endtask

  // monitor
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: none by cycle %0d, expected at cycle %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (cpuEnable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cpuEnable 1 at cycle %0d, expected 0", cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", 32'(stepCount), 32'(e.cnt));
      end
    end
  end

  initial begin
    // reset state
    #12;
    check("rst_state", 32'(state), 0);
    check("rst_en", 32'(cpuEnable), 0);
    check("rst_count", 32'(stepCount), 0);
    @(negedge clock);
    reset = 1'b1;

    // free run: 5 pulses
    runMode = 1'b1;
    idle(4);
    check("run_state", 32'(state), 1);
    for (int i = 0; i < 5; i++) slow_period(1'b1);
    check("run_count", 32'(stepCount), 32'(ecnt()));
    check("run_state_end", 32'(state), 1);

    // single step with a bouncing button
    do_reset();
    runMode = 1'b0;
    idle(4);
    check("step_idle", 32'(state), 0);
    @(negedge clock) stepButton = 1'b1;
    @(negedge clock) stepButton = 1'b0;
    @(negedge clock) stepButton = 1'b1;
    idle(6);
    stepButton = 1'b0;
    idle(4);
    check("step_wait", 32'(state), 2);
    clean_press();                       // second press in STEP_WAIT, dropped
    check("step_wait_hold", 32'(state), 2);
    slow_period(1'b1);
    check("step_done_state", 32'(state), 0);
    check("step_done_count", 32'(stepCount), 32'(ecnt()));
    idle(10);
    check("step_not_queued", 32'(state), 0);

    // halt beats a simultaneous tick
    do_reset();
    runMode = 1'b1;
    idle(4);
    slow_period(1'b1);
    @(negedge clock);
    slowClock = 1'b1;
    idle(2);                             // tick is live during the next cycle
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    check("halt_state", 32'(state), 3);
    idle(8);
    slowClock = 1'b0;
    idle(10);
    slow_period(1'b0);
    clean_press();
    runMode = 1'b0;
    idle(4);
    check("halt_sticky", 32'(state), 3);
    check("halt_count", 32'(stepCount), 32'(ecnt()));

    // wrap
    do_reset();
    runMode = 1'b1;
    idle(4);
`ifdef STEP_COUNTER_EN
    force dut.step_cnt_q = 16'hFFFF;
    #1 release dut.step_cnt_q;
    model_cnt = 16'hFFFF;
`endif
    check("wrap_pre", 32'(stepCount), 32'(ecnt()));
    slow_period(1'b1);
    check("wrap_post", 32'(stepCount), 32'(ecnt()));

    // asynchronous reset in STEP_WAIT with slowClock high across release
    do_reset();
    runMode = 1'b0;
    idle(4);
    clean_press();
    check("mid_wait1", 32'(state), 2);
    slow_period(1'b1);
    clean_press();
    check("mid_wait2", 32'(state), 2);
    @(negedge clock);
    slowClock = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    model_cnt = '0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_en", 32'(cpuEnable), 0);
    check("async_count", 32'(stepCount), 0);
    runMode = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(12);
    check("rel_state", 32'(state), 1);
    check("rel_count", 32'(stepCount), 0);
    slowClock = 1'b0;
    idle(5);
    slow_period(1'b1);
    check("rel_first_tick", 32'(stepCount), 32'(ecnt()));

    idle(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
